// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: one 32-bit column per clock.
// Holds the result until downstream accepts; last_round bypasses.
module mix_columns_iter #(
    parameter int word_size  = 8,
    parameter int array_size = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              last_round,
    input  logic [0:word_size*array_size-1]   Data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [0:word_size*array_size-1]   Mixed_Data,
    output logic                              busy
);

    localparam int W = word_size * array_size;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e       state_q;
    state_e       state_d;
    logic [0:W-1] st_q;
    logic [1:0]   col_q;
    logic [0:31]  col_in;
    logic [0:31]  col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [0:31] mix_col(input logic [0:31] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[0:7];
        a1 = c[8:15];
        a2 = c[16:23];
        a3 = c[24:31];
        return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Shared column datapath, selected by the column counter.
    always_comb begin
        col_in  = st_q[32*col_q +: 32];
        col_out = mix_col(col_in);
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: if (in_valid) state_d = last_round ? DONE : CALC;
            CALC: if (col_q == 2'd3) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, column counter and state register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                st_q  <= Data;
                col_q <= 2'd0;
            end else if (state_q == CALC) begin
                st_q[32*col_q +: 32] <= col_out;
                col_q                <= col_q + 2'd1;
            end
        end
    end

    assign Mixed_Data = st_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed testbench for mix_columns_iter.
// Hand-computed vectors, immediate assertions.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         last_round;
    logic [0:127] Data;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] Mixed_Data;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int n;

    logic [0:127] fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    logic [0:127] fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;
    logic [0:127] byp_in   = 128'h0123456789abcdeffedcba9876543210;
    logic [0:127] held;

    mix_columns_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .last_round (last_round),
        .Data       (Data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Mixed_Data (Mixed_Data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [0:127] d, input logic lr);
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        in_valid   = 1'b1;
        Data       = d;
        last_round = lr;
        step();
        in_valid   = 1'b0;
        last_round = 1'b0;
    endtask

    task automatic wait_out();
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [0:127] d,
                           input logic [0:127] e);
        out_ready = 1'b1;
        send(d, 1'b0);
        wait_out();
        chk({tag, "_lat"}, 128'(n), 128'd4);
        chk({tag, "_data"}, Mixed_Data, e);
        step();
        chk({tag, "_ovld_fall"}, 128'(out_valid), 128'd0);
        chk({tag, "_irdy"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        last_round = 1'b0;
        Data       = '0;
        out_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_irdy", 128'(in_ready), 128'd1);
        chk("rst_ovld", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_data", Mixed_Data, 128'd0);

        run_vec("fips", fips_in, fips_out);
        run_vec("c1", {4{32'hdb135345}}, {4{32'h8e4da1bc}});
        run_vec("c2", {4{32'hf20a225c}}, {4{32'h9fdc589d}});
        run_vec("c3", {4{32'h01010101}}, {4{32'h01010101}});
        run_vec("c4", {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}});
        run_vec("c5", {4{32'hd4d4d4d5}}, {4{32'hd5d5d7d6}});
        run_vec("c6", {4{32'h2d26314c}}, {4{32'h4d7ebdf8}});

        // reset in the middle of CALC (col = 2)
        out_ready = 1'b1;
        send(fips_in, 1'b0);
        step();
        step();
        chk("mid_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("mrst_irdy", 128'(in_ready), 128'd1);
        chk("mrst_ovld", 128'(out_valid), 128'd0);
        chk("mrst_busy", 128'(busy), 128'd0);
        chk("mrst_data", Mixed_Data, 128'd0);

        // bypass
        out_ready = 1'b0;
        send(byp_in, 1'b1);
        step();
        chk("byp_ovld", 128'(out_valid), 128'd1);
        chk("byp_data", Mixed_Data, byp_in);
        out_ready = 1'b1;
        step();
        chk("byp_fall", 128'(out_valid), 128'd0);

        // backpressure
        out_ready = 1'b0;
        send(fips_in, 1'b0);
        wait_out();
        chk("bp_lat", 128'(n), 128'd4);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            Data     = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("bp_data", Mixed_Data, fips_out);
            chk("bp_irdy", 128'(in_ready), 128'd0);
            chk("bp_ovld", 128'(out_valid), 128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_fall", 128'(out_valid), 128'd0);
        chk("bp_irdy1", 128'(in_ready), 128'd1);
        chk("bp_keep", Mixed_Data, fips_out);

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        held      = {4{32'hdb135345}};
        Data      = held;
        in_valid  = 1'b1;
        step();
        Data = fips_in;
        wait_out();
        chk("b2b1_lat", 128'(n), 128'd4);
        chk("b2b1_data", Mixed_Data, {4{32'h8e4da1bc}});
        step();
        chk("b2b_irdy", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        chk("b2b2_busy", 128'(busy), 128'd1);
        wait_out();
        chk("b2b2_lat", 128'(n), 128'd4);
        chk("b2b2_data", Mixed_Data, fips_out);
        step();
        chk("b2b2_fall", 128'(out_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
